// File: rtl/seg_scan_mux_pkg.sv
// Shared constants for the multiplexed 7-segment display blocks.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package seg_pkg;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   localparam logic [15:0][6:0] HEX_SEG = {
      7'b0001110,  // F
      7'b0000110,  // E
      7'b0100001,  // d
      7'b1000110,  // C
      7'b0000011,  // b
      7'b0001000,  // A
      7'b0010000,  // 9
      7'b0000000,  // 8
      7'b1111000,  // 7
      7'b0000010,  // 6
      7'b0010010,  // 5
      7'b0011001,  // 4
      7'b0110000,  // 3
      7'b0100100,  // 2
      7'b1111001,  // 1
      7'b1000000   // 0
   };

   typedef enum logic {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } state_e;

endpackage

// File: rtl/seg_scan_mux_if.sv
// Display data source / board pin bundle for seg_scan_mux.
// master = measurement side and pin observer, slave = the scanner.
interface seg_scan_mux_if #(
   parameter int NUM_DIGITS = 4
);
   logic [4*NUM_DIGITS-1:0] data;
   logic [NUM_DIGITS-1:0]   dp_mask;
   logic [NUM_DIGITS-1:0]   blank_mask;
   logic                    load;
   logic                    load_ack;
   logic                    frame_start;
   logic [NUM_DIGITS-1:0]   en;
   logic [6:0]              svn_conf;
   logic                    DP;

   modport master (
      output data, dp_mask, blank_mask, load,
      input  load_ack, frame_start, en, svn_conf, DP
   );

   modport slave (
      input  data, dp_mask, blank_mask, load,
      output load_ack, frame_start, en, svn_conf, DP
   );
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
// Shared by the display blocks; pattern table lives in seg_pkg.
module seg7_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0] hex_i,
   output logic [6:0] seg_o
);
   assign seg_o = HEX_SEG[hex_i];
endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed common-anode 7-segment scanner with blanking and
// frame-synchronous snapshot. Option: LEADING_ZERO_BLANK_EN.
module seg_scan_mux
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int DIV        = 48000,
   parameter int BLANK_CYC  = 256
)(
   input  logic         clk_16M,
   input  logic         rst,
   seg_scan_mux_if.slave bus
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int DW = 4 * NUM_DIGITS;
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_BLK = CW'(BLANK_CYC);
   localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
   localparam state_e ST_RST = (BLANK_CYC == 0) ? DRIVE : BLANK;

   logic [CW-1:0]         cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   state_e                state_q, state_d;
   logic                  pend_q, pend_d;
   logic [DW-1:0]         shd_q, shd_d;
   logic [NUM_DIGITS-1:0] shp_q, shp_d;
   logic [NUM_DIGITS-1:0] shb_q, shb_d;
   logic [NUM_DIGITS-1:0] en_q, en_d;
   logic [6:0]            svn_q, svn_d;
   logic                  dp_q, dp_d;
   logic                  ack_q, ack_d;
   logic                  fs_q, fs_d;
   logic                  boundary;
   logic [3:0]            nib;
   logic [6:0]            seg;
   logic                  lz;

   assign boundary = (cnt_q == '0) && (idx_q == '0);

   always_comb begin
      cnt_d   = cnt_q + 1'b1;
      idx_d   = idx_q;
      if (cnt_q == CNT_MAX) begin
         cnt_d = '0;
         idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
      end
      state_d = (cnt_d < CNT_BLK) ? BLANK : DRIVE;
   end

   // Capture into the shadow only on the frame boundary
   always_comb begin
      pend_d = pend_q;
      shd_d  = shd_q;
      shp_d  = shp_q;
      shb_d  = shb_q;
      ack_d  = 1'b0;
      if (boundary && (pend_q || bus.load)) begin
         shd_d  = bus.data;
         shp_d  = bus.dp_mask;
         shb_d  = bus.blank_mask;
         ack_d  = 1'b1;
         pend_d = 1'b0;
      end else if (bus.load) begin
         pend_d = 1'b1;
      end
   end

   assign nib = shd_d[{idx_q, 2'b00} +: 4];

   seg7_hex_decode u_dec (
      .hex_i (nib),
      .seg_o (seg)
   );

`ifdef LEADING_ZERO_BLANK_EN
   logic [IW-1:0] msd;

   always_comb begin
      msd = '0;
      for (int i = 1; i < NUM_DIGITS; i++) begin
         if (shd_d[4*i +: 4] != 4'h0) msd = IW'(i);
      end
   end

   assign lz = (idx_q > msd);
`else
   assign lz = 1'b0;
`endif

   always_comb begin
      en_d  = '1;
      svn_d = SEG_OFF;
      dp_d  = 1'b1;
      fs_d  = boundary;
      if (state_q == DRIVE) begin
         en_d[idx_q] = 1'b0;
         svn_d = (shb_d[idx_q] || lz) ? SEG_OFF : seg;
         dp_d  = shb_d[idx_q] | ~shp_d[idx_q];
      end
   end

   always_ff @(posedge clk_16M) begin
      if (rst) begin
         cnt_q   <= '0;
         idx_q   <= '0;
         state_q <= ST_RST;
         pend_q  <= 1'b0;
         shd_q   <= '0;
         shp_q   <= '0;
         shb_q   <= '0;
         en_q    <= '1;
         svn_q   <= SEG_OFF;
         dp_q    <= 1'b1;
         ack_q   <= 1'b0;
         fs_q    <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         state_q <= state_d;
         pend_q  <= pend_d;
         shd_q   <= shd_d;
         shp_q   <= shp_d;
         shb_q   <= shb_d;
         en_q    <= en_d;
         svn_q   <= svn_d;
         dp_q    <= dp_d;
         ack_q   <= ack_d;
         fs_q    <= fs_d;
      end
   end

   assign bus.en          = en_q;
   assign bus.svn_conf    = svn_q;
   assign bus.DP          = dp_q;
   assign bus.load_ack    = ack_q;
   assign bus.frame_start = fs_q;
endmodule
